// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule stage: takes one 512-bit padded block and streams W[0..63].
// Expansion runs in place over a 16-word circular buffer indexed by t mod 16.
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         reset,
  input  logic [511:0] blk_data,
  input  logic         blk_valid,
  output logic         blk_ready,
  output logic [31:0]  w_word,
  output logic [5:0]   w_index,
  output logic         w_valid,
  input  logic         w_ready,
  output logic         w_last,
  output logic         busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and once raised w_valid holds until W63 transfers.

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] buf_q [16];
  logic [31:0] buf_d [16];

  logic [3:0]  idx_m2, idx_m7, idx_m15, idx_m16;
  logic [31:0] expanded;
  logic        streaming;
  logic        w_xfer;
  logic        blk_xfer;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Offsets into the ring; the 4-bit wrap gives the mod-16 addressing for free.
  always_comb begin
    idx_m2   = t_q[3:0] - 4'd2;
    idx_m7   = t_q[3:0] - 4'd7;
    idx_m15  = t_q[3:0] - 4'd15;
    idx_m16  = t_q[3:0];
    expanded = small_sigma1(buf_q[idx_m2]) + buf_q[idx_m7]
             + small_sigma0(buf_q[idx_m15]) + buf_q[idx_m16];
  end

  always_comb begin
    streaming = (state_q == S_STREAM);
    blk_ready = !streaming;
    w_valid   = streaming;
    busy      = streaming;
    w_index   = streaming ? t_q : 6'd0;
    w_last    = streaming && (t_q == 6'd63);
    if (!streaming) begin
      w_word = 32'd0;
    end else if (t_q < 6'd16) begin
      w_word = buf_q[t_q[3:0]];
    end else begin
      w_word = expanded;
    end
    w_xfer   = w_valid && w_ready;
    blk_xfer = blk_valid && blk_ready;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (blk_xfer) begin
          for (int k = 0; k < 16; k++) begin
            buf_d[k] = blk_data[32*(15-k) +: 32];
          end
          t_d     = 6'd0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_xfer) begin
          // Overwrites W[t-16], the oldest word, which no later round reads.
          buf_d[t_q[3:0]] = w_word;
          t_d             = t_q + 6'd1;
          if (t_q == 6'd63) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      t_q     <= 6'd0;
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int k = 0; k < 16; k++) begin
        buf_q[k] <= buf_d[k];
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Testbench for sha256_msg_schedule: full 64-word schedule reference model, stalls,
// back-to-back blocks and reset behaviour.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         reset;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic         w_valid;
  logic         w_ready;
  logic         w_last;
  logic         busy;

  int checks;
  int failures;

  logic [31:0] exp_q [$];
  logic [31:0] got_w [64];

  localparam logic [511:0] ABC_BLK  = {32'h61626380, 448'd0, 32'h00000018};
  localparam logic [511:0] ZERO_BLK = {256'd0, 32'h80000000, 192'd0, 32'h00000100};

  sha256_msg_schedule dut (
    .clk       (clk),
    .reset     (reset),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .w_word    (w_word),
    .w_index   (w_index),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_last    (w_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: textbook full 64-entry schedule array, pushed into the expected queue.
  task automatic load_expected(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s0, s1;
    exp_q.delete();
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) exp_q.push_back(w[t]);
  endtask

  // Called at the falling edge right after acceptance; ends at the falling edge after W63 moves.
  task automatic run_words(input bit stall, input string tag);
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    while (n < 64 && cyc < 2000) begin
      checks++;
      if (w_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_w_valid t=%0d got=%b exp=1", tag, n, w_valid);
      end
      checks++;
      if (w_index !== 6'(n)) begin
        failures++;
        $display("FAIL %s_w_index got=%0d exp=%0d", tag, w_index, n);
      end
      checks++;
      if (w_word !== exp_q[0]) begin
        failures++;
        $display("FAIL %s_w_word t=%0d got=%h exp=%h", tag, n, w_word, exp_q[0]);
      end
      checks++;
      if (w_last !== ((n == 63) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL %s_w_last t=%0d got=%b exp=%b", tag, n, w_last, (n == 63));
      end
      checks++;
      if (blk_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL %s_busy t=%0d got_ready=%b got_busy=%b exp=0/1", tag, n, blk_ready, busy);
      end
      w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_ready && w_valid) begin
        got_w[n] = w_word;
        void'(exp_q.pop_front());
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (n != 64) begin
      failures++;
      $display("FAIL %s_timeout got=%0d words exp=64", tag, n);
    end
    exp_q.delete();
    checks++;
    if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_word !== 32'd0 || w_last !== 1'b0) begin
      failures++;
      $display("FAIL %s_end got_valid=%b got_ready=%b got_word=%h exp=0/1/0", tag, w_valid,
               blk_ready, w_word);
    end
  endtask

  task automatic send_and_run(input logic [511:0] blk, input bit stall, input string tag);
    load_expected(blk);
    blk_data  = blk;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    blk_data  = {16{$urandom()}};
    run_words(stall, tag);
  endtask

  task automatic test_reset();
    checks++;
    if (blk_ready !== 1'b1 || w_valid !== 1'b0 || w_word !== 32'd0 || w_index !== 6'd0 ||
        w_last !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got ready=%b valid=%b word=%h idx=%0d last=%b busy=%b",
               blk_ready, w_valid, w_word, w_index, w_last, busy);
    end
  endtask

  task automatic test_abc();
    send_and_run(ABC_BLK, 1'b0, "abc");
    checks++;
    if (got_w[16] !== 32'h61626380) begin
      failures++;
      $display("FAIL abc_w16 got=%h exp=61626380", got_w[16]);
    end
    checks++;
    if (got_w[17] !== 32'h000F0000) begin
      failures++;
      $display("FAIL abc_w17 got=%h exp=000f0000", got_w[17]);
    end
    checks++;
    if (got_w[18] !== 32'h7DA86405) begin
      failures++;
      $display("FAIL abc_w18 got=%h exp=7da86405", got_w[18]);
    end
    checks++;
    if (got_w[63] !== 32'h12B1EDEB) begin
      failures++;
      $display("FAIL abc_w63 got=%h exp=12b1edeb", got_w[63]);
    end
  endtask

  task automatic test_zero_msg();
    send_and_run(ZERO_BLK, 1'b0, "zero");
    checks++;
    if (got_w[16] !== 32'h00000000) begin
      failures++;
      $display("FAIL zero_w16 got=%h exp=00000000", got_w[16]);
    end
    checks++;
    if (got_w[17] !== 32'h00A00000) begin
      failures++;
      $display("FAIL zero_w17 got=%h exp=00a00000", got_w[17]);
    end
  endtask

  task automatic test_stall();
    send_and_run(ABC_BLK, 1'b1, "stall_abc");
    checks++;
    if (got_w[63] !== 32'h12B1EDEB) begin
      failures++;
      $display("FAIL stall_w63 got=%h exp=12b1edeb", got_w[63]);
    end
  endtask

  task automatic test_random_blocks();
    logic [511:0] blk;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom();
      send_and_run(blk, b[0], "rand");
    end
  endtask

  task automatic test_back_to_back();
    logic [511:0] blk_b;
    for (int k = 0; k < 16; k++) blk_b[32*k +: 32] = $urandom();
    load_expected(ABC_BLK);
    blk_data  = ABC_BLK;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_data = blk_b;
    run_words(1'b1, "b2b_first");
    load_expected(blk_b);
    @(negedge clk);
    blk_valid = 1'b0;
    run_words(1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_stream();
    blk_data  = ABC_BLK;
    blk_valid = 1'b1;
    w_ready   = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
    for (int i = 0; i < 30; i++) @(negedge clk);
    checks++;
    if (w_index !== 6'd30 || w_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got_idx=%0d got_valid=%b exp=30/1", w_index, w_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (w_valid !== 1'b0 || w_word !== 32'd0 || blk_ready !== 1'b1 || busy !== 1'b0 ||
        w_index !== 6'd0) begin
      failures++;
      $display("FAIL midrst_abort got_valid=%b got_word=%h got_ready=%b got_idx=%0d exp=0/0/1/0",
               w_valid, w_word, blk_ready, w_index);
    end
    @(negedge clk);
    checks++;
    if (w_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet got=%b exp=0", w_valid);
    end
    send_and_run(ABC_BLK, 1'b0, "midrst_abc");
  endtask

  task automatic test_reset_hold();
    load_expected(ABC_BLK);
    reset     = 1'b1;
    blk_data  = ABC_BLK;
    blk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (w_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rsthold_cycle%0d got_valid=%b got_busy=%b exp=0/0", i, w_valid, busy);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    blk_valid = 1'b0;
    run_words(1'b0, "rsthold");
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    blk_data  = '0;
    blk_valid = 1'b0;
    w_ready   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_zero_msg();
    test_stall();
    test_random_blocks();
    test_back_to_back();
    test_reset_mid_stream();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
